// File: rtl/shapool_defs.sv
// Shared definitions for the nonce search stage: state encoding and default geometry.
package shapool_defs;

    localparam int unsigned DEF_NONCE_WIDTH    = 32;
    localparam int unsigned DEF_POOL_SIZE_LOG2 = 2;
    localparam int unsigned DEF_HASH_TOP_WIDTH = 32;
    localparam int unsigned DEF_LATENCY        = 2;
    localparam int unsigned DIFF_W             = 6;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StRun       = 3'd1,
        StDrain     = 3'd2,
        StFound     = 3'd3,
        StExhausted = 3'd4
    } state_e;

endpackage

// File: rtl/difficulty_match.sv
// Per-unit leading-zero difficulty compare with lowest-index priority selection.
module difficulty_match
    import shapool_defs::*;
#(
    parameter int unsigned POOL_SIZE_LOG2 = DEF_POOL_SIZE_LOG2,
    parameter int unsigned HASH_TOP_WIDTH = DEF_HASH_TOP_WIDTH
) (
    input  logic [DIFF_W-1:0]                             difficulty,
    input  logic [(2**POOL_SIZE_LOG2)*HASH_TOP_WIDTH-1:0] hash_top,
    input  logic                                          hash_valid,
    output logic                                          any_match,
    output logic [POOL_SIZE_LOG2-1:0]                     match_idx
);

    localparam int unsigned POOL = 2**POOL_SIZE_LOG2;

    logic [31:0]               w_req;
    logic [HASH_TOP_WIDTH-1:0] w_mask;
    logic [POOL-1:0]           w_unit_match;

    // Mask covers the top w_req bits; oversized difficulty saturates at the full word.
    always_comb begin
        w_req = 32'(difficulty);
        if (w_req > HASH_TOP_WIDTH) begin
            w_req = HASH_TOP_WIDTH;
        end
        w_mask = '0;
        for (int unsigned b = 0; b < HASH_TOP_WIDTH; b++) begin
            w_mask[HASH_TOP_WIDTH-1-b] = (b < w_req);
        end
    end

    always_comb begin
        w_unit_match = '0;
        for (int i = 0; i < int'(POOL); i++) begin
            w_unit_match[i] = hash_valid &&
                ((hash_top[i*HASH_TOP_WIDTH +: HASH_TOP_WIDTH] & w_mask) == '0);
        end
    end

    always_comb begin
        any_match = |w_unit_match;
        match_idx = '0;
        for (int i = int'(POOL) - 1; i >= 0; i--) begin
            if (w_unit_match[i]) begin
                match_idx = POOL_SIZE_LOG2'(i);
            end
        end
    end

endmodule

// File: rtl/nonce_control.sv
// Nonce counter issue and success detection for the hash pool.
// Define NONCE_CORRECT_EN to report the exact matching nonce rather than the live counter.
module nonce_control
    import shapool_defs::*;
#(
    parameter int unsigned NONCE_WIDTH    = DEF_NONCE_WIDTH,
    parameter int unsigned POOL_SIZE_LOG2 = DEF_POOL_SIZE_LOG2,
    parameter int unsigned HASH_TOP_WIDTH = DEF_HASH_TOP_WIDTH,
    parameter int unsigned LATENCY        = DEF_LATENCY
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          start,
    input  logic                                          halt,
    input  logic [NONCE_WIDTH-POOL_SIZE_LOG2-1:0]         nonce_start,
    input  logic [DIFF_W-1:0]                             difficulty,
    input  logic [(2**POOL_SIZE_LOG2)*HASH_TOP_WIDTH-1:0] hash_top,
    input  logic                                          hash_valid,
    output logic [NONCE_WIDTH-POOL_SIZE_LOG2-1:0]         nonce,
    output logic                                          nonce_valid,
    output logic                                          shapool_success,
    output logic [NONCE_WIDTH-1:0]                        shapool_result,
    output logic                                          exhausted
);

    localparam int unsigned CW  = NONCE_WIDTH - POOL_SIZE_LOG2;
    localparam int unsigned DCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e                   r_state;
    logic [CW-1:0]            r_nonce;
    logic                     r_nonce_valid;
    logic                     r_success;
    logic [NONCE_WIDTH-1:0]   r_result;
    logic                     r_exhausted;
    logic [DCW-1:0]           r_drain_cnt;

    logic                      w_any_match;
    logic [POOL_SIZE_LOG2-1:0] w_match_idx;
    logic [CW-1:0]             w_field;
    logic                      w_checking;

    assign w_checking = (r_state == StRun) || (r_state == StDrain);

    difficulty_match #(
        .POOL_SIZE_LOG2 (POOL_SIZE_LOG2),
        .HASH_TOP_WIDTH (HASH_TOP_WIDTH)
    ) u_match (
        .difficulty (difficulty),
        .hash_top   (hash_top),
        .hash_valid (hash_valid),
        .any_match  (w_any_match),
        .match_idx  (w_match_idx)
    );

`ifdef NONCE_CORRECT_EN
    // Tracks what was issued LATENCY cycles ago, i.e. the nonce behind this hash_valid.
    logic [CW-1:0] r_issued [LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_issued[i] <= '0;
            end
        end else begin
            r_issued[0] <= r_nonce;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_issued[i] <= r_issued[i-1];
            end
        end
    end

    assign w_field = r_issued[LATENCY-1];
`else
    assign w_field = r_nonce;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_nonce       <= '0;
            r_nonce_valid <= 1'b0;
            r_success     <= 1'b0;
            r_result      <= '0;
            r_exhausted   <= 1'b0;
            r_drain_cnt   <= '0;
        end else begin
            case (r_state)
                StIdle, StFound, StExhausted: begin
                    if (start) begin
                        r_state       <= StRun;
                        r_nonce       <= nonce_start;
                        r_nonce_valid <= 1'b1;
                        r_success     <= 1'b0;
                        r_exhausted   <= 1'b0;
                        r_drain_cnt   <= '0;
                    end
                end
                StRun, StDrain: begin
                    // A match outranks halt and drain expiry.
                    if (w_checking && w_any_match) begin
                        r_state       <= StFound;
                        r_nonce_valid <= 1'b0;
                        r_success     <= 1'b1;
                        r_result      <= {w_match_idx, w_field};
                    end else if (r_state == StRun) begin
                        if (halt) begin
                            r_state       <= StIdle;
                            r_nonce_valid <= 1'b0;
                        end else if (r_nonce == '1) begin
                            r_state       <= StDrain;
                            r_nonce_valid <= 1'b0;
                            r_drain_cnt   <= '0;
                        end else begin
                            r_nonce <= r_nonce + 1'b1;
                        end
                    end else if (r_drain_cnt == DCW'(LATENCY - 1)) begin
                        r_state     <= StExhausted;
                        r_exhausted <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state       <= StIdle;
                    r_nonce_valid <= 1'b0;
                end
            endcase
        end
    end

    assign nonce           = r_nonce;
    assign nonce_valid     = r_nonce_valid;
    assign shapool_success = r_success;
    assign shapool_result  = r_result;
    assign exhausted       = r_exhausted;

endmodule

// File: tb/tb_nonce_control.sv
// Scoreboard bench for nonce_control: a search-level model queues expected events,
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_nonce_control;

    localparam int unsigned NW   = 32;
    localparam int unsigned PL   = 2;
    localparam int unsigned HW   = 32;
    localparam int unsigned LAT  = 2;
    localparam int unsigned CW   = NW - PL;
    localparam int unsigned POOL = 1 << PL;

    typedef enum int {EvNonce = 0, EvSuccess = 1, EvExhausted = 2} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [31:0] val;
    } ev_t;

    logic                 clk;
    logic                 reset_n;
    logic                 start;
    logic                 halt;
    logic [CW-1:0]        nonce_start;
    logic [5:0]           difficulty;
    logic [POOL*HW-1:0]   hash_top;
    logic                 hash_valid;
    logic [CW-1:0]        nonce;
    logic                 nonce_valid;
    logic                 shapool_success;
    logic [NW-1:0]        shapool_result;
    logic                 exhausted;

    int  n_checks = 0;
    int  n_errors = 0;
    ev_t sb[$];

    nonce_control #(
        .NONCE_WIDTH    (NW),
        .POOL_SIZE_LOG2 (PL),
        .HASH_TOP_WIDTH (HW),
        .LATENCY        (LAT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .halt            (halt),
        .nonce_start     (nonce_start),
        .difficulty      (difficulty),
        .hash_top        (hash_top),
        .hash_valid      (hash_valid),
        .nonce           (nonce),
        .nonce_valid     (nonce_valid),
        .shapool_success (shapool_success),
        .shapool_result  (shapool_result),
        .exhausted       (exhausted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: DUT output with no expected event at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic bit unit_hit(input logic [HW-1:0] top, input logic [5:0] d);
        int dc;
        dc = (d > 6'd32) ? 32 : int'(d);
        if (dc == 0) return 1'b1;
        return (top >> (32 - dc)) == '0;
    endfunction

    function automatic bit find_winner(input logic [POOL*HW-1:0] top, input logic [5:0] d,
                                       output int idx);
        idx = 0;
        for (int i = 0; i < int'(POOL); i++) begin
            if (unit_hit(top[i*HW +: HW], d)) begin
                idx = i;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // k-th issued nonce; the counter sticks at all-ones once the range is used up.
    function automatic logic [CW-1:0] nonce_at(input logic [CW-1:0] s, input longint r,
                                               input int k);
        longint kk;
        kk = (longint'(k) < r) ? longint'(k) : r - 1;
        return s + CW'(kk);
    endfunction

    task automatic stim_for(input int scen, input int c, input longint r,
                            output logic hv, output logic [POOL*HW-1:0] top, output logic h);
        hv  = 1'b0;
        h   = 1'b0;
        top = '1;
        case (scen)
            0: begin
                if (c >= int'(LAT) && $urandom_range(0, 3) == 0) begin
                    hv = 1'b1;
                    for (int i = 0; i < int'(POOL); i++) begin
                        top[i*HW +: HW] = $urandom >> $urandom_range(0, 32);
                    end
                end
                if (longint'(c) < r && (c >= 40 || $urandom_range(0, 19) == 0)) h = 1'b1;
            end
            2: if (c == 5) begin hv = 1'b1; top[2*HW +: HW] = 32'h00FF_FFFF; end
            3: if (c == 4) begin
                hv = 1'b1;
                top[1*HW +: HW] = 32'h0000_ABCD;
                top[3*HW +: HW] = 32'h0000_1234;
            end
            5: if (c == 3) begin hv = 1'b1; top = '0; end
            6: if (c == 3) begin hv = 1'b1; h = 1'b1; top[3*HW +: HW] = 32'h0FFF_FFFF; end
            7: if (c == 3) h = 1'b1;
            8: begin
                if (c == 2) begin
                    hv = 1'b1;
                    for (int i = 0; i < int'(POOL); i++) top[i*HW +: HW] = 32'h0000_0001;
                end else if (c == 3) begin
                    hv = 1'b1;
                    top[2*HW +: HW] = '0;
                end
            end
            9: if (c == 2) hv = 1'b1;
            default: ;
        endcase
    endtask

    task automatic run_search(input logic [CW-1:0] s, input logic [5:0] d, input int scen);
        longint             r;
        int                 c;
        int                 idx;
        bit                 done;
        logic               hv;
        logic               h;
        logic [POOL*HW-1:0] top;
        logic [CW-1:0]      fld;
        r    = (longint'(1) << CW) - longint'(s);
        c    = 0;
        done = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; nonce_start = s; difficulty = d;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done) begin
            stim_for(scen, c, r, hv, top, h);
            if (longint'(c) < r) sb.push_back('{EvNonce, 32'(s + CW'(c))});
            if (hv && find_winner(top, d, idx)) begin
`ifdef NONCE_CORRECT_EN
                fld = nonce_at(s, r, c - int'(LAT));
`else
                fld = nonce_at(s, r, c);
`endif
                sb.push_back('{EvSuccess, {2'(idx), fld}});
                done = 1'b1;
            end else if (h) begin
                done = 1'b1;
            end else if (longint'(c) == r + longint'(LAT) - 1) begin
                sb.push_back('{EvExhausted, 32'd0});
                done = 1'b1;
            end
            // A start while searching must be ignored.
            if (scen == 0 && longint'(c) < r && $urandom_range(0, 9) == 0) begin
                start = 1'b1;
                nonce_start = CW'($urandom);
            end
            hash_valid = hv; hash_top = top; halt = h;
            @(posedge clk); #1;
            start = 1'b0;
            c++;
        end
        halt = 1'b0;
        hash_top = '0;
        repeat (3) begin
            hash_valid = 1'($urandom);
            @(posedge clk); #1;
        end
        hash_valid = 1'b0;
    endtask

    task automatic reset_mid_run();
        @(posedge clk); #1;
        start = 1'b1; nonce_start = 30'h120; difficulty = 6'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sb.push_back('{EvNonce, 32'(32'h120 + c)});
            @(posedge clk); #1;
        end
        check("pre_reset_nonce", 32'(nonce), 32'h123);
        check("pre_reset_valid", 32'(nonce_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_nonce", 32'(nonce), 32'd0);
        check("rst_nonce_valid", 32'(nonce_valid), 32'd0);
        check("rst_success", 32'(shapool_success), 32'd0);
        check("rst_result", shapool_result, 32'd0);
        check("rst_exhausted", 32'(exhausted), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", 32'(nonce_valid), 32'd0);
    endtask

    // ---------------- monitor ----------------
    logic          prev_succ = 1'b0;
    logic          prev_exh  = 1'b0;
    logic [NW-1:0] prev_res  = '0;

    always @(negedge clk) begin
        ev_t e;
        if (reset_n) begin
            if (nonce_valid) begin
                if (sb.size() == 0) fail_now("nonce_unexpected");
                else begin
                    e = sb.pop_front();
                    check("ev_kind_nonce", 32'(e.kind), 32'(EvNonce));
                    check("nonce", 32'(nonce), e.val);
                end
            end
            if (shapool_success && !prev_succ) begin
                if (sb.size() == 0) fail_now("success_unexpected");
                else begin
                    e = sb.pop_front();
                    check("ev_kind_success", 32'(e.kind), 32'(EvSuccess));
                    check("result", shapool_result, e.val);
                end
            end
            if (shapool_success && prev_succ) check("result_hold", shapool_result, prev_res);
            if (exhausted && !prev_exh) begin
                if (sb.size() == 0) fail_now("exhausted_unexpected");
                else begin
                    e = sb.pop_front();
                    check("ev_kind_exhausted", 32'(e.kind), 32'(EvExhausted));
                end
            end
            if (shapool_success || exhausted) check("done_no_valid", 32'(nonce_valid), 32'd0);
            if (shapool_success && exhausted) fail_now("success_and_exhausted");
        end
        prev_succ <= shapool_success;
        prev_exh  <= exhausted;
        prev_res  <= shapool_result;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [CW-1:0] s;
        logic [5:0]    d;
        reset_n = 1'b0; start = 1'b0; halt = 1'b0; hash_valid = 1'b0;
        nonce_start = '0; difficulty = '0; hash_top = '0;
        #12;
        check("init_nonce", 32'(nonce), 32'd0);
        check("init_nonce_valid", 32'(nonce_valid), 32'd0);
        check("init_success", 32'(shapool_success), 32'd0);
        check("init_result", shapool_result, 32'd0);
        check("init_exhausted", 32'(exhausted), 32'd0);
        #10 reset_n = 1'b1;

        run_search(30'h100, 6'd8, 2);
        run_search(30'h200, 6'd16, 3);
        run_search(30'h3FFF_FFFE, 6'd8, 4);
        run_search(30'h3FFF_FFFE, 6'd8, 5);
        run_search(30'h40, 6'd4, 6);
        run_search(30'h50, 6'd4, 7);
        run_search(30'h60, 6'd40, 8);
        run_search(30'h70, 6'd0, 9);
        reset_mid_run();

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) s = CW'((longint'(1) << CW) - $urandom_range(1, 6));
            else s = CW'($urandom);
            case ($urandom_range(0, 7))
                0: d = 6'd0;
                1: d = 6'($urandom_range(33, 63));
                default: d = 6'($urandom_range(1, 24));
            endcase
            run_search(s, d, 0);
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nonce_control.md
Name: nonce_control

Overview:
- Nonce-generation and success-detection stage directly upstream of the SPI/IO block.
- Issues a per-cycle nonce counter to the hash pool and checks each hash unit's final top word against a leading-zero difficulty.
- On a match, drives `shapool_success` and `shapool_result`, which the IO block latches and shifts out.
- Handles pipeline latency, pool exhaustion, and the external halt (IO `ready`).

Parameters:
- NONCE_WIDTH, 32, full nonce width. Counter width is CW = NONCE_WIDTH-POOL_SIZE_LOG2.
- POOL_SIZE_LOG2, 2, log2 of the number of hash units (POOL = 2**POOL_SIZE_LOG2).
- HASH_TOP_WIDTH, 32, width of each unit's top hash word.
- LATENCY, 2, cycles from a nonce being issued to its hash_valid result (>=1).

Ports:
- clk  in  1  core clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; loads nonce_start, begins search
- halt  in  1  level; stop searching (driven from IO `ready`)
- nonce_start  in  CW  first counter value
- difficulty  in  6  required leading zero bits of top word; values >HASH_TOP_WIDTH clamp to HASH_TOP_WIDTH
- hash_top  in  POOL*HASH_TOP_WIDTH  unit i at bits [i*HASH_TOP_WIDTH +: HASH_TOP_WIDTH]
- hash_valid  in  1  hash_top valid this cycle
- nonce  out  CW  counter to units; each unit prepends its own index
- nonce_valid  out  1  nonce is being issued this cycle
- shapool_success  out  1  match found, held
- shapool_result  out  NONCE_WIDTH  {unit index, counter field}
- exhausted  out  1  range finished with no match, held

Behaviour:
- Async reset: state=IDLE; nonce=0; nonce_valid=0; shapool_success=0; shapool_result=0; exhausted=0; delay line and drain counter=0.
- States:
  - IDLE: outputs quiescent. start -> RUN; nonce<=nonce_start; success and exhausted cleared.
  - RUN: nonce_valid=1; nonce increments by 1 every cycle.
    - Issuing nonce all-ones -> DRAIN; counter holds and does not wrap.
    - halt -> IDLE.
  - DRAIN: nonce_valid=0. Still checks hash_valid for exactly LATENCY cycles (counter drain_cnt). Expiry -> EXHAUSTED.
  - FOUND: shapool_success=1, result frozen, nonce frozen, nonce_valid=0.
  - EXHAUSTED: exhausted=1.
  - start in FOUND, EXHAUSTED or IDLE restarts exactly as from IDLE. start in RUN or DRAIN is ignored.
- Match detection:
  - Unit i matches when hash_valid=1 and its top `difficulty` bits are all zero. difficulty=0 means any valid hash matches.
  - Multiple matching units: lowest index wins.
  - A match is checked in RUN and DRAIN only. It is registered: FOUND and shapool_success=1 appear at the edge after the matching hash_valid cycle.
  - shapool_result[NONCE_WIDTH-1 -: POOL_SIZE_LOG2] = winning index; the low CW bits are the counter field (see Optional Feature).
- Precedence: match in the same cycle as halt -> FOUND, not IDLE. Match in the final DRAIN cycle -> FOUND, not EXHAUSTED.
- hash_valid in IDLE, FOUND or EXHAUSTED is ignored.
- Reset mid-operation: immediate return to reset values. The pipeline is not flushed; the next start restarts cleanly.
- Latency: start -> first nonce_valid on the following cycle.

Optional Feature:
- Macro NONCE_CORRECT_EN.
- Defined:
  - A LATENCY-deep shift register tracks issued nonces.
  - The counter field of the result is the exact nonce that produced the match.
- Undefined:
  - The counter field is the nonce register value at the matching cycle, i.e. ahead by LATENCY (mod 2**CW) during RUN.
  - The host corrects it; this saves LATENCY*CW flops.
  - During DRAIN the held counter is reported uncorrected.

Decomposition:
- Shared package shapool_defs:
  - state encodings (IDLE, RUN, DRAIN, FOUND, EXHAUSTED; 3 bits)
  - default NONCE_WIDTH, POOL_SIZE_LOG2, LATENCY
  - difficulty width constant
- One sub-module: difficulty_match.
  - Combinational per-unit clamped leading-zero compare plus lowest-index priority encoder.
  - Outputs any_match and match_idx.

Test Plan (POOL_SIZE_LOG2=2, LATENCY=2, CW=30):
1. Reset asserted mid-RUN with nonce=0x123 -> all outputs 0 immediately, state IDLE, no nonce_valid.
2. start, nonce_start=0x100, difficulty=8. The cycle nonce=0x105, hash_valid=1 and unit 2 top=0x00FFFFFF -> next edge shapool_success=1. Result 0x80000103 with NONCE_CORRECT_EN; 0x80000105 without.
3. Units 1 and 3 both match the same cycle -> result index field = 1.
4. nonce_start=0x3FFFFFFE, no matches -> nonce_valid for 2 cycles, 2 DRAIN cycles, then exhausted=1, shapool_success=0. A match on DRAIN cycle 2 instead -> FOUND.
5. halt and a matching hash_valid in the same cycle -> FOUND, success=1. halt alone in RUN -> IDLE, nonce_valid=0 next cycle.
6. difficulty=40 (clamped to 32): top=0x00000001 -> no match; top=0x00000000 -> match. difficulty=0: any hash_valid matches.
